// File: rtl/rtc_bus_sequencer_if.sv
// rtl/rtc_bus_sequencer_if.sv - request/response and RTC pin bundle for rtc_bus_sequencer
interface rtc_bus_sequencer_if;
  logic       start;
  logic       rw;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       busy;
  logic       done;
  logic       CS;
  logic       AD;
  logic       RD;
  logic       WR;
  logic [7:0] dat_RTC_out;
  logic       dat_RTC_oe;
  logic [7:0] dat_RTC_in;

  modport slave (
    input  start, rw, addr, wdata, dat_RTC_in,
    output rdata, busy, done, CS, AD, RD, WR, dat_RTC_out, dat_RTC_oe
  );

  modport master (
    output start, rw, addr, wdata, dat_RTC_in,
    input  rdata, busy, done, CS, AD, RD, WR, dat_RTC_out, dat_RTC_oe
  );
endinterface

// File: rtl/rtc_bus_sequencer.sv
// rtl/rtc_bus_sequencer.sv - multiplexed address/data RTC bus engine
// Optional address-phase skip on repeated address: define RTC_ADDR_SKIP_EN.
module rtc_bus_sequencer #(
  parameter int T_SU  = 2,
  parameter int T_PW  = 4,
  parameter int T_H   = 2,
  parameter int T_GAP = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  rtc_bus_sequencer_if.slave   bus
);

  typedef enum logic [3:0] {
    IDLE, A_SU, A_PW, A_H, GAP, D_SU, D_PW, D_H, DONE
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       rw_q, rw_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;

  logic       cs_q, cs_d;
  logic       ad_q, ad_d;
  logic       rd_q, rd_d;
  logic       wr_q, wr_d;
  logic       oe_q, oe_d;
  logic [7:0] out_q, out_d;
  logic [7:0] rdata_q, rdata_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic       in_addr, in_data;

`ifdef RTC_ADDR_SKIP_EN
  logic       skip_vld_q, skip_vld_d;
  logic [7:0] skip_addr_q, skip_addr_d;
  logic       skip_hit;
`endif

  function automatic logic [7:0] cnt_load(state_e s);
    case (s)
      A_SU, D_SU: cnt_load = 8'(T_SU - 1);
      A_PW, D_PW: cnt_load = 8'(T_PW - 1);
      A_H,  D_H:  cnt_load = 8'(T_H - 1);
      GAP:        cnt_load = 8'(T_GAP - 1);
      default:    cnt_load = 8'd0;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef RTC_ADDR_SKIP_EN
    skip_vld_d  = skip_vld_q;
    skip_addr_d = skip_addr_q;
    skip_hit    = skip_vld_q && (bus.addr == skip_addr_q);
`endif

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          rw_d    = bus.rw;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
`ifdef RTC_ADDR_SKIP_EN
          state_d = skip_hit ? D_SU : A_SU;
`else
          state_d = A_SU;
`endif
        end
      end
      A_SU:    if (cnt_q == 8'd0) state_d = A_PW;
      A_PW:    if (cnt_q == 8'd0) state_d = A_H;
      A_H:     if (cnt_q == 8'd0) state_d = GAP;
      GAP:     if (cnt_q == 8'd0) state_d = D_SU;
      D_SU:    if (cnt_q == 8'd0) state_d = D_PW;
      D_PW:    if (cnt_q == 8'd0) state_d = D_H;
      D_H:     if (cnt_q == 8'd0) state_d = DONE;
      DONE: begin
        state_d = IDLE;
`ifdef RTC_ADDR_SKIP_EN
        skip_vld_d  = 1'b1;
        skip_addr_d = addr_q;
`endif
      end
      default: state_d = IDLE;
    endcase

    // Every timed state exits when its counter reaches zero, so a state change is a fresh entry.
    if (state_d != state_q) begin
      cnt_d = cnt_load(state_d);
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end

    in_addr = (state_q == A_SU) || (state_q == A_PW) || (state_q == A_H);
    in_data = (state_q == D_SU) || (state_q == D_PW) || (state_q == D_H);

    cs_d    = !(in_addr || in_data);
    ad_d    = !in_addr;
    wr_d    = !((state_q == A_PW) || ((state_q == D_PW) && !rw_q));
    rd_d    = !((state_q == D_PW) && rw_q);
    oe_d    = in_addr || (in_data && !rw_q);
    out_d   = in_addr ? addr_q : ((in_data && !rw_q) ? wdata_q : 8'h00);
    done_d  = (state_q == DONE);
    busy_d  = (state_q != IDLE) || bus.start;
    // Capture on the edge where RD returns high.
    rdata_d = (!rd_q && rd_d) ? bus.dat_RTC_in : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      rw_q    <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      cs_q    <= 1'b1;
      ad_q    <= 1'b1;
      rd_q    <= 1'b1;
      wr_q    <= 1'b1;
      oe_q    <= 1'b0;
      out_q   <= 8'h00;
      rdata_q <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef RTC_ADDR_SKIP_EN
      skip_vld_q  <= 1'b0;
      skip_addr_q <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cs_q    <= cs_d;
      ad_q    <= ad_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      oe_q    <= oe_d;
      out_q   <= out_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef RTC_ADDR_SKIP_EN
      skip_vld_q  <= skip_vld_d;
      skip_addr_q <= skip_addr_d;
`endif
    end
  end

  assign bus.CS          = cs_q;
  assign bus.AD          = ad_q;
  assign bus.RD          = rd_q;
  assign bus.WR          = wr_q;
  assign bus.dat_RTC_oe  = oe_q;
  assign bus.dat_RTC_out = out_q;
  assign bus.rdata       = rdata_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// tb/tb_rtc_bus_sequencer.sv - randomized self-checking bench for rtc_bus_sequencer
module tb_rtc_bus_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rtc_bus_sequencer_if bif0 ();
  rtc_bus_sequencer_if bif1 ();

  rtc_bus_sequencer dut0 (.clk(clk), .reset(reset), .bus(bif0));
  rtc_bus_sequencer #(.T_PW(1), .T_GAP(1)) dut1 (.clk(clk), .reset(reset), .bus(bif1));

  int su[2] = '{2, 2};
  int pw[2] = '{4, 1};
  int hd[2] = '{2, 2};
  int gp[2] = '{3, 1};

  int n_tests = 0;
  int n_fail  = 0;

  bit         skip_vld[2];
  logic [7:0] skip_addr[2];
  logic [7:0] rdata_exp[2];

  // {CS, AD, RD, WR, oe, bus-out-when-driven, done, busy}
  localparam logic [14:0] IDLE_V = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] obs(input int sel);
    if (sel == 0)
      return {bif0.CS, bif0.AD, bif0.RD, bif0.WR, bif0.dat_RTC_oe,
              bif0.dat_RTC_oe ? bif0.dat_RTC_out : 8'h00, bif0.done, bif0.busy};
    else
      return {bif1.CS, bif1.AD, bif1.RD, bif1.WR, bif1.dat_RTC_oe,
              bif1.dat_RTC_oe ? bif1.dat_RTC_out : 8'h00, bif1.done, bif1.busy};
  endfunction

  function automatic logic [7:0] rdata_of(input int sel);
    return (sel == 0) ? bif0.rdata : bif1.rdata;
  endfunction

  // Expected pins in cycle c after the start-sampling edge, from the phase durations.
  function automatic logic [14:0] exp_vec(input int sel, input int c, input bit skip,
                                          input bit rw, input logic [7:0] a, input logic [7:0] wd);
    int ph, aph, d0, dend, q;
    bit strobe;
    ph   = su[sel] + pw[sel] + hd[sel];
    aph  = skip ? 0 : ph;
    d0   = aph + (skip ? 0 : gp[sel]);
    dend = d0 + ph;
    if (c < aph) begin
      strobe = (c >= su[sel]) && (c < su[sel] + pw[sel]);
      return {1'b0, 1'b0, 1'b1, !strobe, 1'b1, a, 1'b0, 1'b1};
    end
    if (c < d0) return {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
    if (c < dend) begin
      q = c - d0;
      strobe = (q >= su[sel]) && (q < su[sel] + pw[sel]);
      if (rw) return {1'b0, 1'b1, !strobe, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
      return {1'b0, 1'b1, 1'b1, !strobe, 1'b1, wd, 1'b0, 1'b1};
    end
    if (c == dend) return {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1};
    return IDLE_V;
  endfunction

  task automatic drive(input int sel, input bit st, input bit rw, input logic [7:0] a,
                       input logic [7:0] wd, input logic [7:0] din);
    if (sel == 0) begin
      bif0.start = st; bif0.rw = rw; bif0.addr = a; bif0.wdata = wd; bif0.dat_RTC_in = din;
    end else begin
      bif1.start = st; bif1.rw = rw; bif1.addr = a; bif1.wdata = wd; bif1.dat_RTC_in = din;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      skip_vld[i]  = 1'b0;
      rdata_exp[i] = 8'h00;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check("idle0", obs(0), IDLE_V);
      check("idle1", obs(1), IDLE_V);
    end
  endtask

  // Entered and left #1 after a rising edge. rst_at: edge at which reset is sampled (0 = none).
  task automatic run_txn(input int sel, input bit rw, input logic [7:0] a, input logic [7:0] wd,
                         input logic [7:0] din, input bit extra, input int rst_at);
    bit skip;
    int lat;
    logic [14:0] v;
`ifdef RTC_ADDR_SKIP_EN
    skip = skip_vld[sel] && (skip_addr[sel] == a);
`else
    skip = 1'b0;
`endif
    lat = skip ? 1 + su[sel] + pw[sel] + hd[sel]
               : 1 + 2 * (su[sel] + pw[sel] + hd[sel]) + gp[sel];
    drive(sel, 1'b1, rw, a, wd, ~din);
    @(posedge clk); #1;
    drive(sel, 1'b0, ~rw, ~a, ~wd, ~din);
    for (int e = 1; e <= lat + 1; e++) begin
      @(posedge clk); #1;
      v = obs(sel);
      if (rst_at != 0 && e == rst_at) begin
        check("rst_pins", v, IDLE_V);
        check("rst_rdata", {24'h0, rdata_of(sel)}, 32'h0);
        reset = 1'b0;
        model_reset();
        idle_cycles(3);
        return;
      end
      check($sformatf("pins%0d_e%0d", sel, e), v, exp_vec(sel, e - 1, skip, rw, a, wd));
      if (rst_at != 0 && e == rst_at - 1) reset = 1'b1;
      if (extra && (e == 4 || e == lat - 1))
        drive(sel, 1'b1, $urandom_range(0, 1), 8'($urandom), 8'($urandom), v[12] ? ~din : din);
      else
        drive(sel, 1'b0, rw, a, wd, v[12] ? ~din : din);
    end
    if (rw) rdata_exp[sel] = din;
    skip_vld[sel]  = 1'b1;
    skip_addr[sel] = a;
    check($sformatf("rdata%0d", sel), {24'h0, rdata_of(sel)}, {24'h0, rdata_exp[sel]});
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    check("preset0", obs(0), IDLE_V);
    check("preset1", obs(1), IDLE_V);
  endtask

  initial begin
    logic [7:0] a;
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_pins0", obs(0), IDLE_V);
    check("reset_pins1", obs(1), IDLE_V);
    check("reset_rdata0", {24'h0, rdata_of(0)}, 32'h0);
    reset = 1'b0;
    idle_cycles(2);

    run_txn(0, 1'b0, 8'h02, 8'h21, 8'h99, 1'b0, 0);
    run_txn(0, 1'b1, 8'h03, 8'h00, 8'h45, 1'b0, 0);
    run_txn(0, 1'b0, 8'h10, 8'h5A, 8'h00, 1'b1, 0);
    idle_cycles(1);
    run_txn(0, 1'b0, 8'h11, 8'hC3, 8'h00, 1'b0, 8);
    run_txn(0, 1'b0, 8'h11, 8'hC3, 8'h00, 1'b0, 0);
    run_txn(1, 1'b1, 8'h07, 8'h00, 8'hA7, 1'b0, 0);

    pulse_reset();
    run_txn(0, 1'b1, 8'h05, 8'h00, 8'h31, 1'b0, 0);
    run_txn(0, 1'b1, 8'h05, 8'h00, 8'h32, 1'b1, 0);
    run_txn(0, 1'b1, 8'h06, 8'h00, 8'h33, 1'b0, 0);
    pulse_reset();
    run_txn(0, 1'b1, 8'h06, 8'h00, 8'h34, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0: a = 8'h05;
        1: a = 8'h06;
        default: a = 8'($urandom);
      endcase
      run_txn($urandom_range(0, 1), $urandom_range(0, 1), a, 8'($urandom), 8'($urandom),
              $urandom_range(0, 1), ($urandom_range(0, 9) == 0) ? $urandom_range(2, 8) : 0);
      idle_cycles($urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
